// File: rtl/keypad_entry.sv
// Hex keypad front end: scans a 4x4 active-low matrix, debounces whole-frame
// results and shifts each accepted digit into an 8-bit operand register.
module keypad_entry #(
   parameter int SCAN_DIV   = 10000,
   parameter int DEB_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] key_row,
   input  logic [3:0] key_col,
   input  logic       clr,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held,
   output logic [7:0] entry
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam int CNT_W = $clog2(DEB_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEB_FRAMES);

   typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;
   typedef enum logic [1:0] {ST_IDLE, ST_PRESS_CNT, ST_HELD, ST_RELEASE_CNT} state_t;

   logic [DIV_W-1:0] div_reg;
   logic [1:0]       slot_reg;
   logic [3:0]       col_sync;
   res_t             acc_res_reg;
   logic [3:0]       acc_code_reg;
   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [3:0]       cand_reg;
   logic             key_valid_reg;
   logic [3:0]       key_code_reg;
   logic             key_held_reg;
   logic [7:0]       entry_reg;

   // Per-column two-flop synchronizer; idle level is high (pulled up)
   for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
         if (rst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
         end else begin
            meta_reg <= key_col[gi];
            sync_reg <= meta_reg;
         end
      end
      assign col_sync[gi] = sync_reg;
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign key_row[gi] = (slot_reg != 2'(gi));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg  <= '0;
         slot_reg <= 2'd0;
      end else if (div_reg == DIV_LAST) begin
         div_reg  <= '0;
         slot_reg <= slot_reg + 2'd1;
      end else begin
         div_reg <= div_reg + DIV_W'(1);
      end
   end

   logic sample_tick;
   logic frame_end;
   assign sample_tick = (div_reg == DIV_LAST);
   assign frame_end   = sample_tick && (slot_reg == 2'd3);

   logic [3:0] row_low;
   logic [2:0] row_cnt;
   logic [1:0] row_col;
   assign row_low = ~col_sync;

   always_comb begin
      row_cnt = 3'd0;
      row_col = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (row_low[i]) begin
            row_cnt = row_cnt + 3'd1;
            row_col = 2'(i);
         end
      end
   end

   // Fold the current row into the running frame result; slot 0 starts fresh
   res_t       base_res;
   res_t       frame_res;
   logic [3:0] frame_code;
   assign base_res = (slot_reg == 2'd0) ? RES_NONE : acc_res_reg;

   always_comb begin
      frame_res  = base_res;
      frame_code = acc_code_reg;
      if (row_cnt >= 3'd2 || base_res == RES_MULTI ||
          (base_res == RES_SINGLE && row_cnt == 3'd1)) begin
         frame_res = RES_MULTI;
      end else if (row_cnt == 3'd1) begin
         frame_res  = RES_SINGLE;
         frame_code = {slot_reg, row_col};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_res_reg  <= RES_NONE;
         acc_code_reg <= 4'd0;
      end else if (sample_tick) begin
         acc_res_reg  <= frame_res;
         acc_code_reg <= frame_code;
      end
   end

   logic             is_single;
   logic             is_none;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;
   logic             release_done;
   assign is_single = (frame_res == RES_SINGLE);
   assign is_none   = (frame_res == RES_NONE);
   assign cnt_inc   = cnt_reg + CNT_W'(1);

   assign accept = frame_end && is_single &&
      ((state_reg == ST_IDLE && DEB_FRAMES == 1) ||
       (state_reg == ST_PRESS_CNT && frame_code == cand_reg && cnt_inc == CNT_DONE));
   assign release_done = frame_end && is_none &&
      ((state_reg == ST_HELD && DEB_FRAMES == 1) ||
       (state_reg == ST_RELEASE_CNT && cnt_inc == CNT_DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         cand_reg      <= 4'd0;
         key_valid_reg <= 1'b0;
         key_code_reg  <= 4'd0;
         key_held_reg  <= 1'b0;
         entry_reg     <= 8'd0;
      end else begin
         key_valid_reg <= accept;
         // clr beats a simultaneous accept for entry, but the event still fires
         if (clr) begin
            entry_reg <= 8'd0;
         end else if (accept) begin
            entry_reg <= {entry_reg[3:0], frame_code};
         end
         if (accept) begin
            key_code_reg <= frame_code;
            key_held_reg <= 1'b1;
         end else if (release_done) begin
            key_held_reg <= 1'b0;
         end
         if (frame_end) begin
            case (state_reg)
               ST_IDLE: begin
                  if (is_single) begin
                     cand_reg  <= frame_code;
                     cnt_reg   <= CNT_W'(1);
                     state_reg <= (DEB_FRAMES == 1) ? ST_HELD : ST_PRESS_CNT;
                  end
               end
               ST_PRESS_CNT: begin
                  if (is_single && frame_code == cand_reg) begin
                     cnt_reg <= cnt_inc;
                     if (cnt_inc == CNT_DONE) state_reg <= ST_HELD;
                  end else begin
                     cnt_reg   <= '0;
                     state_reg <= ST_IDLE;
                  end
               end
               ST_HELD: begin
                  if (is_none) begin
                     cnt_reg   <= CNT_W'(1);
                     state_reg <= (DEB_FRAMES == 1) ? ST_IDLE : ST_RELEASE_CNT;
                  end
               end
               ST_RELEASE_CNT: begin
                  if (is_none) begin
                     cnt_reg <= cnt_inc;
                     if (cnt_inc == CNT_DONE) state_reg <= ST_IDLE;
                  end else begin
                     cnt_reg   <= '0;
                     state_reg <= ST_HELD;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   assign key_valid = key_valid_reg;
   assign key_code  = key_code_reg;
   assign key_held  = key_held_reg;
   assign entry     = entry_reg;

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Hex keypad front end for the calculator: scans a 4x4 active-low matrix keypad, debounces presses and emits one event per press. Each accepted digit is shifted into an 8-bit operand register. This is the operand-entry end of the datapath, complementing the segment display path. It runs on the same generated clock as the calculator core and display.

## Interface

Parameters:
- SCAN_DIV, default 10000: clock cycles each row is driven; must be ≥ 4.
- DEB_FRAMES, default 4: consecutive identical full-scan frames required to accept a press or a release; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_row  out  4  row drive, active-low one-hot.
- key_col  in  4  column sense, active-low (pulled up externally), asynchronous.
- clr  in  1  synchronous clear of `entry`, level-sampled.
- key_valid  out  1  one-cycle pulse per accepted press.
- key_code  out  4  code of the last accepted key; held between pulses.
- key_held  out  1  high from acceptance until release is accepted.
- entry  out  8  operand; each accepted digit enters the low nibble.

## Operation

- `key_col` passes through a 2-flop synchronizer before any use.
- Row scan:
  - A divider counts 0..SCAN_DIV-1 per slot; the slot index r cycles 0..3.
  - `key_row` = ~(1<<r).
  - Synchronized columns are sampled only on the last divider cycle of each slot.
- Decode:
  - Column c low in slot r means key r*4+c is down (code = {r[1:0], c[1:0]}).
  - Per frame (slots 0..3), the result is NONE (no key), SINGLE(code) (exactly one key) or MULTI (two or more keys, in one or several rows).
  - The result is evaluated at the slot-3 sample (end of frame).
- Debounce FSM. It updates only at end of frame; `cnt` is the frame counter.
  - IDLE:
    - SINGLE(k) → PRESS_CNT, with cand=k and cnt=1. If DEB_FRAMES=1, accept immediately.
    - NONE or MULTI → stay.
  - PRESS_CNT:
    - SINGLE(cand) → cnt+1. When cnt reaches DEB_FRAMES, accept and go to HELD.
    - Anything else → IDLE.
  - HELD:
    - NONE → RELEASE_CNT, cnt=1. If DEB_FRAMES=1, go straight to IDLE.
    - SINGLE or MULTI → stay. A second key or a change of key gives no new event.
  - RELEASE_CNT:
    - NONE → cnt+1. When cnt reaches DEB_FRAMES → IDLE.
    - Anything else → HELD.
- Accept actions:
  - key_valid=1 for exactly one cycle.
  - key_code=cand.
  - key_held=1.
  - entry = {entry[3:0], cand}.
  - key_held clears on the transition into IDLE from RELEASE_CNT.
- clr:
  - When high, entry=0 on the next edge.
  - If clr coincides with an accept, clr wins: entry=0, but key_valid and key_code still update.
- Reset values:
  - key_row=4'b1110, divider=0, r=0, FSM=IDLE, cnt=0.
  - key_valid=0, key_code=0, key_held=0, entry=0, synchronizer flops=4'b1111.
- Reset mid-press:
  - Everything returns to reset values.
  - A key still held afterwards is treated as a fresh press: it is accepted again after DEB_FRAMES frames.

## Timing

- One frame = 4*SCAN_DIV cycles.
- Column-to-sample latency is 2 cycles (synchronizer). Columns must settle within SCAN_DIV-3 cycles of the row change.
- key_valid rises in the cycle after the end-of-frame sample that completes DEB_FRAMES consecutive SINGLE(cand) frames.
- key_code, entry and key_held update in the same cycle as key_valid.
- Minimum press-to-event time is DEB_FRAMES frames. At most one event per press.
- Repeat presses are separated by at least 2*DEB_FRAMES frames.

## Test plan

Use SCAN_DIV=4, DEB_FRAMES=2 (frame = 16 cycles). The keypad model drives `key_col` from `key_row`.

- Reset:
  - Stimulus: rst high 3 cycles.
  - Response: key_row=1110, key_valid=0, entry=8'h00, key_held=0.
  - After release, key_row rotates 1110→1101→1011→0111 every 4 cycles.
- Single press:
  - Stimulus: press key 9 (row 2, col 1) for 6 frames, then release.
  - Response: exactly one key_valid pulse, key_code=4'h9, entry=8'h09.
  - key_held drops 2 frames after release.
- Digit entry:
  - Stimulus: press/release 3, then A, then 7.
  - Response: entry goes 03 → 3A → A7.
  - Stimulus: then pulse clr.
  - Response: entry=00 while key_code stays 7.
- Bounce:
  - Stimulus: key 5 toggles every 10 cycles for 5 frames, then holds steady.
  - Response: no key_valid until 2 stable frames; then one event with code 5.
- Multi-key:
  - Stimulus: press 1 and E together.
  - Response: no event.
  - Stimulus: hold 1, accept it, then add E.
  - Response: no second event. The release debounce starts only when both keys are released.
- Reset mid-press / clr collision:
  - Stimulus: assert rst during HELD with key 4 still down.
  - Response: key_held=0 immediately, and a new event for 4 after 2 frames.
  - Stimulus: assert clr in the accept cycle.
  - Response: entry=00 and key_valid=1.
